// File: rtl/nonogram_pkg.sv
// nonogram_pkg: shared widths and the option streamer state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nonogram_pkg;

   localparam int SIZE   = 11;
   localparam int OPT_W  = 16;
   localparam int CNT_W  = 7;
   localparam int LINE_W = 5;

   typedef enum logic [2:0] {
      IDLE,
      START,
      INDEX,
      OPT,
      SETTLE,
      RND_END,
      DONE
   } state_t;

endpackage

// File: rtl/option_fifo.sv
// option_fifo: circular buffer of option words, one push and one pop per cycle.
// Latency: head word is read combinationally; a pushed word is poppable the next cycle.
// Backpressure: full/empty flags; a push while full is dropped unless a pop frees a slot.
module option_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 512
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_dat,
   input  logic         pop,
   output logic [W-1:0] pop_dat,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic [W-1:0] mem_q [DEPTH];
   logic         do_push;
   logic         do_pop;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign pop_dat = mem_q[rd_ptr_q[AW-1:0]];

   // Advance each pointer on an accepted push or pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
   end

   // Pointer registers; reset empties the buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
   end

endmodule

// File: rtl/option_streamer.sv
// option_streamer: replays buffered line options to the solver once per round, requeuing survivors.
// Latency: per line 1 index cycle + N option cycles + 1 settle cycle; option word is registered.
// Backpressure: load_ready only in IDLE with buffer space; run is free-running until solved/stall.
// Build option: define STALL_DETECT_EN to stop with stuck=1 after a round that removes nothing.
module option_streamer #(
   parameter int SIZE  = nonogram_pkg::SIZE,
   parameter int OPT_W = nonogram_pkg::OPT_W,
   parameter int DEPTH = 512
) (
   input  logic                                       clk,
   input  logic                                       rst_n,
   input  logic [3:0]                                 num_rows,
   input  logic [3:0]                                 num_cols,
   input  logic                                       load_valid,
   output logic                                       load_ready,
   input  logic [nonogram_pkg::LINE_W-1:0]            load_line,
   input  logic [OPT_W-1:0]                           load_option,
   input  logic                                       go,
   input  logic                                       put_back_to_FIFO,
   input  logic                                       solved,
   output logic                                       started,
   output logic [OPT_W-1:0]                           option,
   output logic [2*SIZE:0][nonogram_pkg::CNT_W-1:0]   old_options_amnt,
   output logic                                       busy,
   output logic                                       done,
   output logic                                       stuck,
   output logic [7:0]                                 round
);

   import nonogram_pkg::*;

   localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(2*SIZE);

   state_t                          state_q, state_d;
   logic [LINE_W-1:0]               line_q, line_d;
   logic [LINE_W-1:0]               num_lines_q, num_lines_d;
   logic [CNT_W-1:0]                rem_q, rem_d;
   logic [CNT_W-1:0]                new_cnt_q, new_cnt_d;
   logic [OPT_W-1:0]                option_q, option_d;
   logic [7:0]                      round_q, round_d;
   logic [2*SIZE:0][CNT_W-1:0]      cnt_q, cnt_d;
   logic                            solved_seen_q, solved_seen_d;
`ifdef STALL_DETECT_EN
   logic                            changed_q, changed_d;
   logic                            stuck_q, stuck_d;
`endif

   logic                            fifo_push;
   logic                            fifo_pop;
   logic [OPT_W-1:0]                fifo_push_dat;
   logic [OPT_W-1:0]                fifo_head;
   logic                            fifo_full;
   logic                            fifo_empty;

   option_fifo #(
      .W     (OPT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (fifo_push),
      .push_dat (fifo_push_dat),
      .pop      (fifo_pop),
      .pop_dat  (fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   assign load_ready       = (state_q == IDLE) && !fifo_full;
   assign busy             = (state_q != IDLE) && (state_q != DONE);
   assign done             = (state_q == DONE);
   assign started          = (state_q == START);
   assign option           = option_q;
   assign old_options_amnt = cnt_q;
   assign round            = round_q;
`ifdef STALL_DETECT_EN
   assign stuck            = stuck_q;
`else
   assign stuck            = 1'b0;
`endif

   // Next-state, buffer traffic and count bookkeeping for loading and each round.
   always_comb begin
      state_d       = state_q;
      line_d        = line_q;
      num_lines_d   = num_lines_q;
      rem_d         = rem_q;
      new_cnt_d     = new_cnt_q;
      option_d      = option_q;
      round_d       = round_q;
      cnt_d         = cnt_q;
      solved_seen_d = solved_seen_q;
`ifdef STALL_DETECT_EN
      changed_d     = changed_q;
      stuck_d       = stuck_q;
`endif
      fifo_push     = 1'b0;
      fifo_pop      = 1'b0;
      fifo_push_dat = option_q;

      if (load_valid && load_ready) begin
         fifo_push     = 1'b1;
         fifo_push_dat = load_option;
         if (load_line <= LAST_LINE) cnt_d[load_line] = cnt_q[load_line] + CNT_W'(1);
      end

      // A solve report anywhere in the run is remembered until the next line boundary.
      if (busy && solved) solved_seen_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (go) begin
               state_d       = START;
               num_lines_d   = LINE_W'(num_rows) + LINE_W'(num_cols);
               round_d       = '0;
               solved_seen_d = 1'b0;
            end
         end
         START: begin
            line_d   = '0;
            option_d = '0;
`ifdef STALL_DETECT_EN
            changed_d = 1'b0;
`endif
            state_d  = INDEX;
         end
         INDEX: begin
            new_cnt_d = '0;
            if (cnt_q[line_q] != '0) begin
               fifo_pop = 1'b1;
               option_d = fifo_head;
               rem_d    = cnt_q[line_q] - CNT_W'(1);
               state_d  = OPT;
            end else begin
               state_d  = SETTLE;
            end
         end
         OPT: begin
            // The word on the bus this cycle is requeued if the solver keeps it.
            if (put_back_to_FIFO) begin
               fifo_push     = 1'b1;
               fifo_push_dat = option_q;
               new_cnt_d     = new_cnt_q + CNT_W'(1);
            end
            if (rem_q != '0) begin
               fifo_pop = 1'b1;
               option_d = fifo_head;
               rem_d    = rem_q - CNT_W'(1);
            end else begin
               state_d  = SETTLE;
            end
         end
         SETTLE: begin
            cnt_d[line_q] = new_cnt_q;
`ifdef STALL_DETECT_EN
            if (new_cnt_q < cnt_q[line_q]) changed_d = 1'b1;
`endif
            if (solved_seen_q || solved) begin
               round_d = round_q + 8'd1;
               state_d = DONE;
            end else if (line_q == num_lines_q - LINE_W'(1)) begin
               state_d = RND_END;
            end else begin
               line_d   = line_q + LINE_W'(1);
               option_d = OPT_W'(line_q + LINE_W'(1));
               state_d  = INDEX;
            end
         end
         RND_END: begin
            round_d = round_q + 8'd1;
            if (solved_seen_q || solved) begin
               state_d = DONE;
`ifdef STALL_DETECT_EN
            end else if (!changed_q) begin
               stuck_d = 1'b1;
               state_d = DONE;
`endif
            end else begin
               state_d = START;
            end
         end
         DONE: begin
            if (go) begin
               state_d = IDLE;
`ifdef STALL_DETECT_EN
               stuck_d = 1'b0;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and count registers; reset aborts any run and clears all counts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         line_q        <= '0;
         num_lines_q   <= '0;
         rem_q         <= '0;
         new_cnt_q     <= '0;
         option_q      <= '0;
         round_q       <= '0;
         cnt_q         <= '0;
         solved_seen_q <= 1'b0;
`ifdef STALL_DETECT_EN
         changed_q     <= 1'b0;
         stuck_q       <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         line_q        <= line_d;
         num_lines_q   <= num_lines_d;
         rem_q         <= rem_d;
         new_cnt_q     <= new_cnt_d;
         option_q      <= option_d;
         round_q       <= round_d;
         cnt_q         <= cnt_d;
         solved_seen_q <= solved_seen_d;
`ifdef STALL_DETECT_EN
         changed_q     <= changed_d;
         stuck_q       <= stuck_d;
`endif
      end
   end

endmodule

// File: tb/tb_option_streamer.sv
// tb_option_streamer: drives loads and solver rounds, predicting the option bus from a queue model.
// Latency: n/a.
// Backpressure: n/a.
module tb_option_streamer;

   localparam int SIZE  = 11;
   localparam int OPT_W = 16;
   localparam int DEPTH = 512;
   localparam int NL    = 2*SIZE + 1;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic [3:0]               num_rows = 4'd4;
   logic [3:0]               num_cols = 4'd4;
   logic                     load_valid = 1'b0;
   logic                     load_ready;
   logic [4:0]               load_line = '0;
   logic [OPT_W-1:0]         load_option = '0;
   logic                     go = 1'b0;
   logic                     put_back = 1'b0;
   logic                     solved = 1'b0;
   logic                     started;
   logic [OPT_W-1:0]         option;
   logic [2*SIZE:0][6:0]     amnt;
   logic                     busy, done, stuck;
   logic [7:0]               round;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int               line;
      logic [OPT_W-1:0] opt;
   } ent_t;

   ent_t mq[$];
   int   mcnt [NL];
   int   nlines;
   int   mround;

   option_streamer #(.SIZE(SIZE), .OPT_W(OPT_W), .DEPTH(DEPTH)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .num_rows         (num_rows),
      .num_cols         (num_cols),
      .load_valid       (load_valid),
      .load_ready       (load_ready),
      .load_line        (load_line),
      .load_option      (load_option),
      .go               (go),
      .put_back_to_FIFO (put_back),
      .solved           (solved),
      .started          (started),
      .option           (option),
      .old_options_amnt (amnt),
      .busy             (busy),
      .done             (done),
      .stuck            (stuck),
      .round            (round)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      mq.delete();
      for (int i = 0; i < NL; i++) mcnt[i] = 0;
      mround = 0;
   endtask

   task automatic load_one(input int line, input logic [OPT_W-1:0] opt);
      ent_t e;
      if ($urandom_range(0, 3) == 0) tick();
      load_valid  = 1'b1;
      load_line   = line[4:0];
      load_option = opt;
      checks++;
      if (load_ready !== 1'b1) begin
         $display("FAIL load_ready line=%0d got=%b exp=1", line, load_ready);
         errors++;
      end
      tick();
      load_valid = 1'b0;
      e.line = line;
      e.opt  = opt;
      mq.push_back(e);
      mcnt[line]++;
   endtask

   task automatic load_random(input int rows, input int cols);
      int n;
      num_rows = 4'(rows);
      num_cols = 4'(cols);
      nlines   = rows + cols;
      for (int l = 0; l < nlines; l++) begin
         n = (l == 0) ? $urandom_range(1, 4) : $urandom_range(0, 4);
         for (int k = 0; k < n; k++) load_one(l, 16'($urandom));
      end
   endtask

   // policy 0: keep all; 1: drop 1101 on lines 3 and 6; 2: drop first option, keep rest 3/4 of the time.
   task automatic run_round(input int policy, input int solve_line, output bit finished);
      bit               changed;
      bit               first;
      bit               keep;
      logic [OPT_W-1:0] last;
      int               n;
      int               kept;
      ent_t             e;
      changed  = 1'b0;
      first    = 1'b1;
      finished = 1'b0;
      last     = '0;
      checks++;
      if (started !== 1'b1 || busy !== 1'b1 || round !== 8'(mround)) begin
         $display("FAIL start started=%b busy=%b round=%0d exp 1 1 %0d", started, busy, round, mround);
         errors++;
      end
      for (int l = 0; l < nlines; l++) begin
         n    = mcnt[l];
         kept = 0;
         tick();
         checks++;
         if (option !== 16'(l) || started !== 1'b0) begin
            $display("FAIL index line=%0d option=%h started=%b exp %h 0", l, option, started, 16'(l));
            errors++;
         end
         solved   = (l == solve_line);
         put_back = 1'($urandom_range(0, 1));
         last     = 16'(l);
         for (int k = 0; k < n; k++) begin
            e = mq.pop_front();
            tick();
            solved = 1'b0;
            checks++;
            if (option !== e.opt) begin
               $display("FAIL opt line=%0d k=%0d option=%h exp=%h", l, k, option, e.opt);
               errors++;
            end
            case (policy)
               0:       keep = 1'b1;
               1:       keep = !((l == 3 || l == 6) && e.opt == 16'hd);
               default: keep = first ? 1'b0 : ($urandom_range(0, 3) != 0);
            endcase
            first    = 1'b0;
            put_back = keep;
            if (keep) begin
               mq.push_back(e);
               kept++;
            end
            last = e.opt;
         end
         tick();
         solved = 1'b0;
         checks++;
         if (option !== last) begin
            $display("FAIL settle line=%0d option=%h exp=%h", l, option, last);
            errors++;
         end
         put_back = 1'($urandom_range(0, 1));
         if (kept < mcnt[l]) changed = 1'b1;
         mcnt[l] = kept;
         if (l == solve_line) begin
            tick();
            put_back = 1'b0;
            mround++;
            checks++;
            if (done !== 1'b1 || busy !== 1'b0 || round !== 8'(mround)) begin
               $display("FAIL solved_exit done=%b busy=%b round=%0d exp 1 0 %0d", done, busy, round, mround);
               errors++;
            end
            for (int i = 0; i < NL; i++) begin
               checks++;
               if (amnt[i] !== 7'(mcnt[i])) begin
                  $display("FAIL solved_cnt[%0d] got=%0d exp=%0d", i, amnt[i], mcnt[i]);
                  errors++;
               end
            end
            finished = 1'b1;
            return;
         end
      end
      tick();
      put_back = 1'b0;
      checks++;
      if (busy !== 1'b1 || option !== last || round !== 8'(mround)) begin
         $display("FAIL rnd_end busy=%b option=%h round=%0d exp 1 %h %0d", busy, option, round, last, mround);
         errors++;
      end
      for (int i = 0; i < NL; i++) begin
         checks++;
         if (amnt[i] !== 7'(mcnt[i])) begin
            $display("FAIL round_cnt[%0d] got=%0d exp=%0d", i, amnt[i], mcnt[i]);
            errors++;
         end
      end
      mround++;
      tick();
`ifdef STALL_DETECT_EN
      if (!changed) begin
         checks++;
         if (done !== 1'b1 || stuck !== 1'b1 || round !== 8'(mround)) begin
            $display("FAIL stall_exit done=%b stuck=%b round=%0d exp 1 1 %0d", done, stuck, round, mround);
            errors++;
         end
         finished = 1'b1;
         return;
      end
`endif
      checks++;
      if (started !== 1'b1 || done !== 1'b0) begin
         $display("FAIL next_round started=%b done=%b exp 1 0", started, done);
         errors++;
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (option !== '0 || busy !== 1'b0 || done !== 1'b0 || stuck !== 1'b0 ||
          started !== 1'b0 || round !== 8'd0 || load_ready !== 1'b1 || amnt !== '0) begin
         $display("FAIL reset option=%h busy=%b done=%b stuck=%b started=%b round=%0d ready=%b exp all 0, ready 1",
                  option, busy, done, stuck, started, round, load_ready);
         errors++;
      end
      #2 rst_n = 1'b1;
      tick();
   endtask

   task automatic test_plan();
      int  cnts [8];
      int  exp2 [8];
      int  oi;
      bit  fin;
      logic [OPT_W-1:0] opt;
      cnts = '{3, 3, 3, 1, 2, 4, 1, 3};
      exp2 = '{3, 3, 3, 0, 2, 4, 0, 3};
      model_clear();
      num_rows = 4'd4;
      num_cols = 4'd4;
      nlines   = 8;
      for (int l = 0; l < 8; l++) begin
         for (int k = 0; k < cnts[l]; k++) begin
            oi = k;
            if (l == 0)                opt = (oi == 0) ? 16'h3 : (oi == 1) ? 16'h6 : 16'hc;
            else if (l == 3 || l == 6) opt = 16'hd;
            else                       opt = 16'($urandom_range(0, 15));
            load_one(l, opt);
         end
      end
      for (int l = 0; l < 8; l++) begin
         checks++;
         if (amnt[l] !== 7'(cnts[l])) begin
            $display("FAIL load_cnt[%0d] got=%0d exp=%0d", l, amnt[l], cnts[l]);
            errors++;
         end
      end
      go = 1'b1;
      tick();
      go = 1'b0;
      run_round(1, -1, fin);
      for (int l = 0; l < 8; l++) begin
         checks++;
         if (amnt[l] !== 7'(exp2[l])) begin
            $display("FAIL plan_cnt[%0d] got=%0d exp=%0d", l, amnt[l], exp2[l]);
            errors++;
         end
      end
      run_round(2, -1, fin);
      run_round(0, 2, fin);
      checks++;
      if (round !== 8'd3 || done !== 1'b1) begin
         $display("FAIL plan_solved round=%0d done=%b exp 3 1", round, done);
         errors++;
      end
      go = 1'b1;
      tick();
      go = 1'b0;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b1 || amnt[0] !== 7'(mcnt[0])) begin
         $display("FAIL back_to_idle done=%b busy=%b ready=%b cnt0=%0d exp 0 0 1 %0d", done, busy, load_ready, amnt[0], mcnt[0]);
         errors++;
      end
   endtask

   task automatic test_reset_mid();
      bit fin;
      rst_n = 1'b0;
      #3 rst_n = 1'b1;
      tick();
      model_clear();
      load_random(4, 4);
      go = 1'b1;
      tick();
      go = 1'b0;
      tick();
      tick();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (option !== '0 || busy !== 1'b0 || done !== 1'b0 || stuck !== 1'b0 ||
          started !== 1'b0 || round !== 8'd0 || load_ready !== 1'b1 || amnt !== '0) begin
         $display("FAIL reset_mid option=%h busy=%b done=%b stuck=%b started=%b round=%0d ready=%b exp all 0, ready 1",
                  option, busy, done, stuck, started, round, load_ready);
         errors++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      model_clear();
      checks++;
      if (load_ready !== 1'b1 || amnt !== '0 || busy !== 1'b0) begin
         $display("FAIL after_reset ready=%b busy=%b exp 1 0", load_ready, busy);
         errors++;
      end
      fin = 1'b0;
   endtask

   task automatic test_stall();
      bit fin;
      model_clear();
      load_random(3, 2);
      go = 1'b1;
      tick();
      go = 1'b0;
      run_round(2, -1, fin);
      checks++;
      if (fin !== 1'b0) begin
         $display("FAIL stall_r1 finished=%b exp 0", fin);
         errors++;
      end
      run_round(0, -1, fin);
`ifdef STALL_DETECT_EN
      checks++;
      if (fin !== 1'b1 || round !== 8'd2 || stuck !== 1'b1) begin
         $display("FAIL stall_r2 finished=%b round=%0d stuck=%b exp 1 2 1", fin, round, stuck);
         errors++;
      end
`else
      checks++;
      if (fin !== 1'b0 || stuck !== 1'b0) begin
         $display("FAIL nostall_r2 finished=%b stuck=%b exp 0 0", fin, stuck);
         errors++;
      end
      run_round(0, nlines - 1, fin);
      checks++;
      if (done !== 1'b1 || stuck !== 1'b0 || round !== 8'd3) begin
         $display("FAIL nostall_r3 done=%b stuck=%b round=%0d exp 1 0 3", done, stuck, round);
         errors++;
      end
`endif
      go = 1'b1;
      tick();
      go = 1'b0;
      checks++;
      if (done !== 1'b0 || stuck !== 1'b0) begin
         $display("FAIL stall_idle done=%b stuck=%b exp 0 0", done, stuck);
         errors++;
      end
   endtask

   task automatic test_full();
      rst_n = 1'b0;
      #3 rst_n = 1'b1;
      tick();
      model_clear();
      for (int i = 0; i < DEPTH; i++) load_one(i / 23, 16'(i));
      checks++;
      if (load_ready !== 1'b0) begin
         $display("FAIL full_ready got=%b exp=0", load_ready);
         errors++;
      end
      load_valid  = 1'b1;
      load_line   = 5'd0;
      load_option = 16'hbeef;
      tick();
      tick();
      load_valid = 1'b0;
      checks++;
      if (amnt[0] !== 7'd23 || amnt[22] !== 7'd6 || load_ready !== 1'b0) begin
         $display("FAIL full_extra cnt0=%0d cnt22=%0d ready=%b exp 23 6 0", amnt[0], amnt[22], load_ready);
         errors++;
      end
      for (int i = 0; i < NL; i++) begin
         checks++;
         if (amnt[i] !== 7'(mcnt[i])) begin
            $display("FAIL full_cnt[%0d] got=%0d exp=%0d", i, amnt[i], mcnt[i]);
            errors++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_plan();
      test_reset_mid();
      test_stall();
      test_full();
      $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached checks=%0d", checks);
      $fatal(1);
   end

endmodule
